// File: rtl/fp_mul_seq_pkg.sv
// Shared types and constants for the sequential binary32 multiplier.
package fp_mul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        NORM_A,
        NORM_B,
        MUL,
        RND,
        OUT
    } state_t;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [22:0] frac;
    } fp_t;

    localparam int BIAS       = 127;
    localparam int EXP_MAX    = 255;
    localparam int MUL_CYCLES = 24;
    localparam logic [31:0] CANON_NAN = 32'h7FC00000;

    // o_flags = {invalid, overflow, underflow, inexact}
    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 0;

    function automatic logic is_nan(input fp_t x);
        return (&x.exp) && (|x.frac);
    endfunction

    function automatic logic is_inf(input fp_t x);
        return (&x.exp) && !(|x.frac);
    endfunction

    function automatic logic is_zero(input fp_t x);
        return !(|x.exp) && !(|x.frac);
    endfunction

endpackage

// File: rtl/fp_mul_seq_if.sv
// Operand and result handshakes of the multiplier.
interface fp_mul_seq_if;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic [3:0]  o_flags;

    modport slave (
        input  i_valid, i_a, i_b, i_ready,
        output o_ready, o_valid, o_result, o_flags
    );

    modport master (
        output i_valid, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_result, o_flags
    );
endinterface

// File: rtl/fp_mul_seq_count_24.sv
// Leading-zero counter over a 24-bit mantissa; all-zero input yields 24.
module count_24 (
    input  logic [23:0] m,
    output logic [4:0]  lzc
);
    always_comb begin
        lzc = 5'd24;
        // Later (higher) set bits override, so the MSB-most one wins.
        for (int i = 0; i < 24; i++) begin
            if (m[i]) lzc = 5'(23 - i);
        end
    end
endmodule

// File: rtl/fp_mul_seq.sv
// Multi-cycle binary32 multiplier: subnormal pre-normalize, shift-add
// mantissa product, round-to-nearest-even, held result.
module fp_mul_seq
    import fp_mul_pkg::*;
(
    input logic        i_clk,
    input logic        i_rst_n,
    fp_mul_seq_if.slave bus
);

    state_t             state;
    logic               sign;
    logic [7:0]         exp_ra, exp_rb;
    logic [22:0]        frac_ra, frac_rb;
    logic [23:0]        man_a;
    logic [23:0]        mplier;
    logic signed [9:0]  exp_a, exp_b;
    logic [47:0]        acc;
    logic [4:0]         cnt;
    logic [31:0]        result;
    logic [3:0]         flags;
    logic               valid_q;

    // ---------------- operand decode at acceptance
    fp_t  in_a, in_b;
    logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, in_special, in_sign;
    logic [31:0] spec_res;
    logic [3:0]  spec_flg;

    assign in_a       = bus.i_a;
    assign in_b       = bus.i_b;
    assign in_sign    = in_a.sign ^ in_b.sign;
    assign a_nan      = is_nan(in_a);
    assign a_inf      = is_inf(in_a);
    assign a_zero     = is_zero(in_a);
    assign b_nan      = is_nan(in_b);
    assign b_inf      = is_inf(in_b);
    assign b_zero     = is_zero(in_b);
    assign in_special = a_nan | a_inf | a_zero | b_nan | b_inf | b_zero;

    always_comb begin
        spec_res = {in_sign, 31'b0};
        spec_flg = 4'b0;
        if (a_nan || b_nan) begin
            spec_res = CANON_NAN;
        end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
            spec_res          = CANON_NAN;
            spec_flg[FLG_INV] = 1'b1;
        end else if (a_inf || b_inf) begin
            spec_res = {in_sign, 8'hFF, 23'b0};
        end
    end

    // ---------------- shared normalizer: one LZC, muxed between A and B
    logic [7:0]        lzc_exp;
    logic [23:0]       lzc_in, norm_man;
    logic [4:0]        lzc;
    logic signed [9:0] base_exp, norm_exp;

    assign lzc_exp  = (state == NORM_B) ? exp_rb : exp_ra;
    assign lzc_in   = (state == NORM_B) ? {|exp_rb, frac_rb} : {|exp_ra, frac_ra};

    count_24 u_lzc (
        .m   (lzc_in),
        .lzc (lzc)
    );

    assign norm_man = lzc_in << lzc;
    assign base_exp = (|lzc_exp) ? $signed({2'b00, lzc_exp}) : 10'sd1;
    assign norm_exp = base_exp - $signed({5'b0, lzc});

    // ---------------- shift-add step: add into the upper half, shift right
    logic [23:0] addend;
    logic [24:0] sum;
    logic [47:0] acc_nxt;

    assign addend  = mplier[0] ? man_a : 24'b0;
    assign sum     = {1'b0, acc[47:24]} + {1'b0, addend};
    assign acc_nxt = {sum, acc[23:1]};

    // ---------------- rounding
    logic              hi, guard, sticky, rnd_up;
    logic [22:0]       mant;
    logic [23:0]       mant_r;
    logic signed [10:0] e_sum, e_adj, e_fin;
    logic [31:0]       rnd_res;
    logic [3:0]        rnd_flg;

    assign hi     = acc[47];
    assign mant   = hi ? acc[46:24] : acc[45:23];
    assign guard  = hi ? acc[23]    : acc[22];
    assign sticky = hi ? |acc[22:0] : |acc[21:0];
    assign rnd_up = guard && (sticky || mant[0]);
    assign mant_r = {1'b0, mant} + {23'b0, rnd_up};
    assign e_sum  = 11'(exp_a) + 11'(exp_b) - 11'(BIAS);
    assign e_adj  = e_sum + $signed({10'b0, hi});
    // A mantissa carry-out leaves mant_r[22:0] already zero.
    assign e_fin  = e_adj + $signed({10'b0, mant_r[23]});

    always_comb begin
        rnd_res = {sign, e_fin[7:0], mant_r[22:0]};
        rnd_flg = 4'b0;
        if (e_fin >= 11'(EXP_MAX)) begin
            rnd_res          = {sign, 8'hFF, 23'b0};
            rnd_flg[FLG_OVF] = 1'b1;
            rnd_flg[FLG_INX] = 1'b1;
        end else if (e_fin <= 11'sd0) begin
            rnd_res          = {sign, 31'b0};
            rnd_flg[FLG_UNF] = 1'b1;
            rnd_flg[FLG_INX] = 1'b1;
        end else begin
            rnd_flg[FLG_INX] = guard | sticky;
        end
    end

    // ---------------- sequencer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            sign    <= 1'b0;
            exp_ra  <= '0;
            exp_rb  <= '0;
            frac_ra <= '0;
            frac_rb <= '0;
            man_a   <= '0;
            mplier  <= '0;
            exp_a   <= '0;
            exp_b   <= '0;
            acc     <= '0;
            cnt     <= '0;
            result  <= '0;
            flags   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        sign    <= in_sign;
                        exp_ra  <= in_a.exp;
                        frac_ra <= in_a.frac;
                        exp_rb  <= in_b.exp;
                        frac_rb <= in_b.frac;
                        if (in_special) begin
                            result  <= spec_res;
                            flags   <= spec_flg;
                            valid_q <= 1'b1;
                            state   <= OUT;
                        end else begin
                            state <= NORM_A;
                        end
                    end
                end
                NORM_A: begin
                    man_a <= norm_man;
                    exp_a <= norm_exp;
                    state <= NORM_B;
                end
                NORM_B: begin
                    mplier <= norm_man;
                    exp_b  <= norm_exp;
                    acc    <= '0;
                    cnt    <= '0;
                    state  <= MUL;
                end
                MUL: begin
                    acc    <= acc_nxt;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'(MUL_CYCLES - 1)) state <= RND;
                end
                RND: begin
                    result  <= rnd_res;
                    flags   <= rnd_flg;
                    valid_q <= 1'b1;
                    state   <= OUT;
                end
                OUT: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_ready  = (state == IDLE);
    assign bus.o_valid  = valid_q;
    assign bus.o_result = result;
    assign bus.o_flags  = flags;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Bench for fp_mul_seq: directed corner cases plus random operands
// against an arithmetic reference model.
module tb_fp_mul_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    fp_mul_seq_if bus();

    fp_mul_seq dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: decode, normalize by value, exact integer product, RNE by remainder.
    task automatic ref_mul(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic [3:0] f, output bit spc);
        logic        s;
        logic        na, nb, ia, ib, za, zb;
        logic [63:0] ma, mb, p, mant, rem, half;
        int          ea, eb, e, sh;
        s  = a[31] ^ b[31];
        na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        ia = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        ib = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        za = (a[30:0] == 0);
        zb = (b[30:0] == 0);
        spc = na | nb | ia | ib | za | zb;
        f = 4'b0;
        if (na || nb)                      r = 32'h7FC00000;
        else if ((ia && zb) || (za && ib)) begin r = 32'h7FC00000; f = 4'b1000; end
        else if (ia || ib)                 r = {s, 8'hFF, 23'b0};
        else if (za || zb)                 r = {s, 31'b0};
        else begin
            ma = {40'b0, (a[30:23] != 0), a[22:0]};
            mb = {40'b0, (b[30:23] != 0), b[22:0]};
            ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
            eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
            while (ma < 64'd8388608) begin ma = ma * 2; ea--; end
            while (mb < 64'd8388608) begin mb = mb * 2; eb--; end
            p  = ma * mb;
            e  = ea + eb - 127;
            sh = 23;
            if (p >= (64'd1 << 47)) begin sh = 24; e++; end
            mant = p >> sh;
            rem  = p % (64'd1 << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && mant % 2 == 1)) mant = mant + 1;
            if (mant == (64'd1 << 24)) begin mant = 64'd1 << 23; e++; end
            if (e >= 255)     begin r = {s, 8'hFF, 23'b0}; f = 4'b0101; end
            else if (e <= 0)  begin r = {s, 31'b0};        f = 4'b0011; end
            else begin
                r = {s, 8'(e), mant[22:0]};
                f = {3'b0, rem != 0};
            end
        end
    endtask

    function automatic logic [31:0] gen_op();
        logic [31:0] x;
        int          k;
        x = $urandom;
        k = $urandom_range(0, 11);
        case (k)
            0: begin x[30:23] = 8'hFF; x[0] = 1'b1; end
            1: x[30:0] = {8'hFF, 23'b0};
            2: x[30:0] = '0;
            3: x[30:23] = 8'h00;
            4: x[30:23] = 8'($urandom_range(200, 254));
            5: x[30:23] = 8'($urandom_range(1, 50));
            default: x[30:23] = 8'($urandom_range(100, 154));
        endcase
        return x;
    endfunction

    // One full transaction; hold > 0 stalls the result side for that many cycles.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input logic [31:0] er, input logic [3:0] ef,
                          input int elat);
        int lat;
        @(negedge clk);
        chk({tag, "_rdy"}, bus.o_ready, 1'b1);
        bus.i_valid = 1'b1;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_a     = $urandom;
        bus.i_b     = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.o_valid && lat < 100);
        if (!bus.o_valid) begin
            chk({tag, "_timeout"}, 1'b0, 1'b1);
            bus.i_ready = 1'b1;
            return;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(elat));
        chk({tag, "_res"}, bus.o_result, er);
        chk({tag, "_flg"}, bus.o_flags, ef);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_res"}, bus.o_result, er);
            chk({tag, "_hold_flg"}, bus.o_flags, ef);
            chk({tag, "_hold_vld"}, bus.o_valid, 1'b1);
            chk({tag, "_hold_rdy"}, bus.o_ready, 1'b0);
        end
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_done_vld"}, bus.o_valid, 1'b0);
        chk({tag, "_done_res"}, bus.o_result, er);
    endtask

    initial begin
        logic [31:0] ra, rb, rr;
        logic [3:0]  rf;
        bit          spc, seen;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_rdy", bus.o_ready, 1'b1);
        chk("rst_vld", bus.o_valid, 1'b0);
        chk("rst_res", bus.o_result, 32'h0);
        chk("rst_flg", bus.o_flags, 4'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("d_1p5x2",  32'h3FC00000, 32'h40000000, 0, 32'h40400000, 4'b0000, 28);
        run_op("d_subn",   32'h00400000, 32'h7F000000, 0, 32'h3F800000, 4'b0000, 28);
        run_op("d_infx0",  32'h7F800000, 32'h00000000, 0, 32'h7FC00000, 4'b1000, 1);
        run_op("d_nan",    32'h7FC00000, 32'h3F800000, 0, 32'h7FC00000, 4'b0000, 1);
        run_op("d_ovf",    32'h7F000000, 32'h7F000000, 0, 32'h7F800000, 4'b0101, 28);
        run_op("d_unf",    32'h00800000, 32'h00800000, 0, 32'h00000000, 4'b0011, 28);
        run_op("d_inx",    32'h3F800001, 32'h3F800001, 5, 32'h3F800002, 4'b0001, 28);
        run_op("d_ninf",   32'hFF800000, 32'h40000000, 0, 32'hFF800000, 4'b0000, 1);
        run_op("d_nzero",  32'h80000000, 32'h3F800000, 0, 32'h00000000 | 32'h80000000, 4'b0000, 1);

        // Reset in the middle of MUL discards the operation.
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_a     = 32'h3FC00000;
        bus.i_b     = 32'h40000000;
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_vld", bus.o_valid, 1'b0);
        chk("mrst_rdy", bus.o_ready, 1'b1);
        chk("mrst_res", bus.o_result, 32'h0);
        chk("mrst_flg", bus.o_flags, 4'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (35) begin
            @(negedge clk);
            if (bus.o_valid) seen = 1'b1;
        end
        chk("mrst_no_result", seen, 1'b0);
        run_op("d_2x2", 32'h40000000, 32'h40000000, 0, 32'h40800000, 4'b0000, 28);

        for (int i = 0; i < 60; i++) begin
            ra = gen_op();
            rb = gen_op();
            ref_mul(ra, rb, rr, rf, spc);
            run_op("rnd", ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                   rr, rf, spc ? 1 : 28);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
